// File: rtl/pulse_peak_detector.sv
// Threshold-crossing pulse detector: reports peak amplitude, time-to-peak and width
// of each pulse, with a dead-time holdoff, pile-up flagging and width saturation.
module pulse_peak_detector #(
  parameter int DATA_WIDTH = 16,
  parameter int TIME_WIDTH = 12,
  parameter int HOLDOFF    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic [DATA_WIDTH-1:0] peak_amplitude,
  output logic [TIME_WIDTH-1:0] peak_time,
  output logic [TIME_WIDTH-1:0] pulse_width,
  output logic                  peak_valid,
  output logic                  pile_up,
  output logic                  width_ovf,
  output logic [15:0]           pulse_count,
  output logic                  busy
);

  localparam logic [TIME_WIDTH-1:0] WIDTH_MAX = {TIME_WIDTH{1'b1}};
  localparam logic [7:0]            HOLD_LAST = 8'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ABOVE   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t                  state_r;
  logic [DATA_WIDTH-1:0]   sample_r;
  logic [DATA_WIDTH-1:0]   thr_r;
  logic                    sample_valid_r;
  logic                    prev_above_r;
  logic [DATA_WIDTH-1:0]   peak_r;
  logic [TIME_WIDTH-1:0]   ptime_r;
  logic [TIME_WIDTH-1:0]   width_r;
  logic [7:0]              hold_cnt_r;
  logic                    pile_pending_r;

  logic                    above_s;
  logic                    crossing_s;
  logic                    greater_s;
  logic                    end_pulse_s;
  logic [TIME_WIDTH-1:0]   width_inc_s;
  logic [DATA_WIDTH-1:0]   peak_upd_s;
  logic [TIME_WIDTH-1:0]   ptime_upd_s;

  assign above_s     = $signed(sample_r) > $signed(thr_r);
  assign crossing_s  = above_s && !prev_above_r;
  // Gated by above_s so a falling sample never replaces the peak.
  assign greater_s   = above_s && ($signed(sample_r) > $signed(peak_r));
  assign width_inc_s = width_r + TIME_WIDTH'(1);
  assign end_pulse_s = !above_s || (width_inc_s == WIDTH_MAX);
  assign peak_upd_s  = greater_s ? sample_r : peak_r;
  assign ptime_upd_s = greater_s ? width_r : ptime_r;

  // Input sample/threshold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_r <= {DATA_WIDTH{1'b0}};
      thr_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      sample_r <= input_data;
      thr_r    <= threshold;
    end
  end

  // Previous-sample above flag; held at 1 until the first real sample after reset
  // has been evaluated, so a signal that is already high cannot trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_valid_r <= 1'b0;
      prev_above_r   <= 1'b1;
    end else begin
      sample_valid_r <= 1'b1;
      prev_above_r   <= sample_valid_r ? above_s : 1'b1;
    end
  end

  // Detection FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= S_IDLE;
      peak_r         <= {DATA_WIDTH{1'b0}};
      ptime_r        <= {TIME_WIDTH{1'b0}};
      width_r        <= {TIME_WIDTH{1'b0}};
      hold_cnt_r     <= 8'd0;
      pile_pending_r <= 1'b0;
      peak_amplitude <= {DATA_WIDTH{1'b0}};
      peak_time      <= {TIME_WIDTH{1'b0}};
      pulse_width    <= {TIME_WIDTH{1'b0}};
      peak_valid     <= 1'b0;
      pile_up        <= 1'b0;
      width_ovf      <= 1'b0;
      pulse_count    <= 16'd0;
      busy           <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (crossing_s) begin
            state_r <= S_ABOVE;
            peak_r  <= sample_r;
            ptime_r <= TIME_WIDTH'(0);
            width_r <= TIME_WIDTH'(1);
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        S_ABOVE: begin
          if (above_s) begin
            peak_r  <= peak_upd_s;
            ptime_r <= ptime_upd_s;
            width_r <= width_inc_s;
          end
          busy <= 1'b1;
          // A still-high sample ends the pulse only when the width saturates.
          if (end_pulse_s) begin
            peak_amplitude <= peak_upd_s;
            peak_time      <= ptime_upd_s;
            pulse_width    <= above_s ? width_inc_s : width_r;
            width_ovf      <= above_s;
            pile_up        <= pile_pending_r;
            pile_pending_r <= 1'b0;
            peak_valid     <= 1'b1;
            if (pulse_count != 16'hFFFF) begin
              pulse_count  <= pulse_count + 16'd1;
            end
            hold_cnt_r     <= 8'd0;
            state_r        <= S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (crossing_s) begin
            pile_pending_r <= 1'b1;
          end
          if (hold_cnt_r == HOLD_LAST) begin
            state_r    <= S_IDLE;
            busy       <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
            busy       <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Directed bench for pulse_peak_detector: expected pulse reports are queued as
// stimulus is driven and compared when peak_valid fires.
module tb_pulse_peak_detector;

  typedef struct {
    logic [15:0] amp;
    logic [11:0] pt;
    logic [11:0] pw;
    logic        pile;
    logic        ovf;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] input_data;
  logic [15:0] threshold;
  logic [15:0] peak_amplitude;
  logic [11:0] peak_time;
  logic [11:0] pulse_width;
  logic        peak_valid;
  logic        pile_up;
  logic        width_ovf;
  logic [15:0] pulse_count;
  logic        busy;

  logic [15:0] in4;
  logic [15:0] thr4;
  logic [15:0] pa4;
  logic [3:0]  pt4;
  logic [3:0]  pw4;
  logic        pv4;
  logic        pile4;
  logic        ovf4;
  logic [15:0] cnt4;
  logic        busy4;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q[$];
  exp_t q4[$];

  pulse_peak_detector #(.DATA_WIDTH(16), .TIME_WIDTH(12), .HOLDOFF(8)) dut (
    .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
    .peak_amplitude(peak_amplitude), .peak_time(peak_time), .pulse_width(pulse_width),
    .peak_valid(peak_valid), .pile_up(pile_up), .width_ovf(width_ovf),
    .pulse_count(pulse_count), .busy(busy)
  );

  pulse_peak_detector #(.DATA_WIDTH(16), .TIME_WIDTH(4), .HOLDOFF(8)) dut4 (
    .clk(clk), .reset(reset), .input_data(in4), .threshold(thr4),
    .peak_amplitude(pa4), .peak_time(pt4), .pulse_width(pw4),
    .peak_valid(pv4), .pile_up(pile4), .width_ovf(ovf4),
    .pulse_count(cnt4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d);
    input_data = 16'(d);
    step();
  endtask

  task automatic push(input int amp, input int pt, input int pw, input bit pile, input bit ovf, input int cnt);
    exp_t e;
    e.amp = 16'(amp); e.pt = 12'(pt); e.pw = 12'(pw);
    e.pile = pile; e.ovf = ovf; e.cnt = 16'(cnt);
    q.push_back(e);
  endtask

  task automatic push4(input int amp, input int pt, input int pw, input bit ovf, input int cnt);
    exp_t e;
    e.amp = 16'(amp); e.pt = 12'(pt); e.pw = 12'(pw);
    e.pile = 1'b0; e.ovf = ovf; e.cnt = 16'(cnt);
    q4.push_back(e);
  endtask

  // Scoreboard for the default-width instance.
  always @(negedge clk) begin
    if (peak_valid === 1'b1) begin
      check("sb_report_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("sb_peak_amplitude", 32'(peak_amplitude), 32'(e.amp));
        check("sb_peak_time", 32'(peak_time), 32'(e.pt));
        check("sb_pulse_width", 32'(pulse_width), 32'(e.pw));
        check("sb_pile_up", 32'(pile_up), 32'(e.pile));
        check("sb_width_ovf", 32'(width_ovf), 32'(e.ovf));
        check("sb_pulse_count", 32'(pulse_count), 32'(e.cnt));
      end
    end
  end

  // Scoreboard for the narrow-width instance.
  always @(negedge clk) begin
    if (pv4 === 1'b1) begin
      check("sb4_report_expected", 32'(q4.size() > 0), 32'd1);
      if (q4.size() > 0) begin
        exp_t e;
        e = q4.pop_front();
        check("sb4_peak_amplitude", 32'(pa4), 32'(e.amp));
        check("sb4_peak_time", 32'(pt4), 32'(e.pt));
        check("sb4_pulse_width", 32'(pw4), 32'(e.pw));
        check("sb4_pile_up", 32'(pile4), 32'(e.pile));
        check("sb4_width_ovf", 32'(ovf4), 32'(e.ovf));
        check("sb4_pulse_count", 32'(cnt4), 32'(e.cnt));
      end
    end
  end

  initial begin
    reset = 1'b1; input_data = 16'd0; threshold = 16'd100; in4 = 16'd0; thr4 = 16'd100;
    repeat (3) step();
    check("rst_peak_amplitude", 32'(peak_amplitude), 32'd0);
    check("rst_pulse_width", 32'(pulse_width), 32'd0);
    check("rst_peak_valid", 32'(peak_valid), 32'd0);
    check("rst_pulse_count", 32'(pulse_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (3) drive(0);

    // Basic pulse: 0,0,150,300,250,90,0
    push(300, 1, 3, 1'b0, 1'b0, 1);
    drive(0); drive(0); drive(150); drive(300);
    check("busy_in_pulse", 32'(busy), 32'd1);
    drive(250); drive(90); drive(0);
    repeat (12) drive(0);
    check("busy_after_holdoff", 32'(busy), 32'd0);
    check("hold_peak_amplitude", 32'(peak_amplitude), 32'd300);
    check("hold_pulse_width", 32'(pulse_width), 32'd3);

    // Tie keeps first occurrence: 0,200,200,50
    push(200, 0, 2, 1'b0, 1'b0, 2);
    drive(0); drive(200); drive(200); drive(50);
    repeat (12) drive(0);

    // Signed compare with negative threshold
    repeat (2) drive(-100);
    threshold = 16'hFFCE;
    push(-20, 0, 1, 1'b0, 1'b0, 3);
    drive(-100); drive(-20); drive(-60);
    repeat (12) drive(-100);
    threshold = 16'd100;
    drive(-100);
    repeat (3) drive(0);

    // Pile-up: second crossing inside holdoff, third pulse reported with pile_up
    push(200, 0, 1, 1'b0, 1'b0, 4);
    drive(0); drive(200); drive(0); drive(0); drive(0); drive(200); drive(0);
    repeat (12) drive(0);
    push(300, 0, 1, 1'b1, 1'b0, 5);
    drive(300); drive(0);
    repeat (12) drive(0);
    check("pile_count", 32'(pulse_count), 32'd5);

    // Width saturation on the 4-bit instance: ramp held above for 20 samples
    push4(164, 14, 15, 1'b1, 1);
    for (int i = 0; i < 20; i++) begin
      in4 = 16'(150 + i);
      step();
    end
    in4 = 16'd0;
    repeat (12) step();
    check("ovf_no_retrigger", 32'(cnt4), 32'd1);
    push4(200, 0, 1, 1'b0, 2);
    in4 = 16'd200; step();
    in4 = 16'd0;
    repeat (12) step();

    // Reset mid-pulse with input held high afterwards
    drive(0); drive(200); drive(200);
    reset = 1'b1;
    drive(200);
    reset = 1'b0;
    check("midrst_pulse_count", 32'(pulse_count), 32'd0);
    check("midrst_peak_amplitude", 32'(peak_amplitude), 32'd0);
    repeat (10) drive(200);
    check("held_busy", 32'(busy), 32'd0);
    check("held_pulse_count", 32'(pulse_count), 32'd0);
    push(150, 0, 1, 1'b0, 1'b0, 1);
    drive(0); drive(0); drive(150); drive(0);
    repeat (12) drive(0);

    check("sb_queue_drained", 32'(q.size()), 32'd0);
    check("sb4_queue_drained", 32'(q4.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_peak_detector.md
PULSE_PEAK_DETECTOR -- requirements
Module: pulse_peak_detector

Interface
REQ-001 Parameter: DATA_WIDTH, 16, width of the signed filter sample and threshold.
REQ-002 Parameter: TIME_WIDTH, 12, width of the timing and width fields.
REQ-003 Parameter: HOLDOFF, 8, number of dead-time cycles after each pulse (1..255).
REQ-004 Port: clk  input  1  single clock; all logic is on the rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: input_data  input  DATA_WIDTH  signed two's-complement filter output, one sample per clk.
REQ-007 Port: threshold  input  DATA_WIDTH  signed trigger level; it is sampled every cycle, and changes take effect on the next sample.
REQ-008 Port: peak_amplitude  output  DATA_WIDTH  signed maximum of the reported pulse.
REQ-009 Port: peak_time  output  TIME_WIDTH  samples from the first above-threshold sample to the peak sample.
REQ-010 Port: pulse_width  output  TIME_WIDTH  count of consecutive above-threshold samples.
REQ-011 Port: peak_valid  output  1  one-cycle strobe that qualifies the result outputs.
REQ-012 Port: pile_up  output  1  set with peak_valid when a crossing occurred during the preceding holdoff.
REQ-013 Port: width_ovf  output  1  set with peak_valid when the pulse was truncated at maximum width.
REQ-014 Port: pulse_count  output  16  number of reported pulses; it saturates at 16'hFFFF.
REQ-015 Port: busy  output  1  high in the ABOVE and HOLDOFF states.

Function
REQ-016 input_data and threshold SHALL each be registered once; s(k) is the registered sample, and all comparisons are signed, using s(k) > thr(k) ("above").
REQ-017 The FSM SHALL have three states: IDLE, ABOVE and HOLDOFF.
REQ-018 IDLE -> ABOVE SHALL occur only on a rising crossing: s(k) above and s(k-1) not above; a signal that is already high SHALL NOT trigger.
REQ-019 On entry to ABOVE, the block SHALL set peak = s(k), peak_time = 0 and width = 1.
REQ-020 In ABOVE, each above sample SHALL increment width; if s(k) > peak, then peak = s(k) and peak_time = width-before-increment.
REQ-021 On ties in ABOVE, the first occurrence SHALL be kept.
REQ-022 The first non-above sample in ABOVE SHALL end the pulse.
   - Results are latched and peak_valid pulses high for exactly 1 cycle, on the clk after that sample is registered; total latency is 2 clk from input_data.
   - The FSM then moves to HOLDOFF.
REQ-023 If width reaches 2^TIME_WIDTH-1 while the signal is still above, the pulse SHALL end on that cycle with width_ovf = 1 and width = 2^TIME_WIDTH-1.
REQ-024 HOLDOFF SHALL last exactly HOLDOFF cycles and then return to IDLE.
REQ-025 Crossings during HOLDOFF SHALL be ignored for detection but SHALL set pile_pending.
REQ-026 pile_pending SHALL be reported as pile_up on the next peak_valid and then cleared.
REQ-027 A rising crossing evaluated on the same cycle HOLDOFF expires SHALL be treated as occurring in HOLDOFF.
REQ-028 pulse_count SHALL increment on each peak_valid and hold at 16'hFFFF.
REQ-029 peak_amplitude, peak_time, pulse_width, pile_up and width_ovf SHALL hold their last reported values between strobes.

Reset
REQ-030 While reset = 1:
   - The FSM SHALL be in IDLE.
   - All outputs, pile_pending and both input registers SHALL be 0.
   - The previous-sample "above" flag SHALL be cleared to 1, so that no crossing is detected on the first sample after reset.
REQ-031 Reset asserted mid-pulse SHALL discard the pulse with no peak_valid; the first above sample after reset SHALL NOT trigger.
REQ-032 Reset SHALL have priority over every other event on the same edge.

Verification
REQ-033 threshold = 100, input 0,0,150,300,250,90,0 -> a single peak_valid with peak_amplitude 300, peak_time 1, pulse_width 3, pile_up 0, pulse_count 1.
REQ-034 threshold = 100, input 0,200,200,50 -> peak_amplitude 200, peak_time 0, pulse_width 2.
REQ-035 threshold = -50, input -100,-20,-60 -> peak_amplitude -20, pulse_width 1; the signed compare is confirmed.
REQ-036 HOLDOFF = 8, a second pulse crossing 3 cycles after peak_valid, then a third pulse after holdoff -> second pulse not reported; third pulse reported with pile_up 1, pulse_count 2.
REQ-037 TIME_WIDTH = 4, input held above threshold for 20 samples -> peak_valid after 15 samples with width_ovf 1, pulse_width 15; no retrigger until the signal drops and re-crosses.
REQ-038 Reset asserted for 1 cycle during ABOVE, with input then held above -> no peak_valid, pulse_count 0, busy 0 until a fresh rising crossing.
